mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage, directly downstream of the execute stage; consumes its control word, ALU result, store data and destination register.
- Contains the EX/MEM pipeline register, a 2^ADDR_W x 16 data memory with configurable multi-cycle access latency, and a small access FSM.
- Drives the EX/MEM forwarding value back to the execute stage and a pipeline stall to all upstream stages.
- Presents the write-back value, destination and register-write strobe to the MEM/WB boundary.

Parameters:
ADDR_W, 8, data-memory word-address width; depth = 2^ADDR_W 16-bit words
MEM_LATENCY, 2, cycles a load/store occupies the stage; legal range 1..15

Ports:
clk  input  1  clock, rising-edge
rest  input  1  reset, asynchronous, active-low
Controll_Signals_In  input  16  control word from execute: [15] RegWrite, [13] MemToReg, [12] MemRead, [11] MemWrite; other bits pass through unchanged
OpCode_In  input  4  opcode from execute
AluResult_In  input  16  ALU result / memory byte-free word address
Store_Data_In  input  16  store data (forwarded Read1 value)
Rd_In  input  4  destination register
Controll_Signals_Out  output  16  registered control word
OpCode_Out  output  4  registered opcode
EXMEMData  output  16  registered ALU result, forwarding source for execute
WB_Data_Out  output  16  MemToReg ? MemData_Out : EXMEMData
MemData_Out  output  16  load data
Rd_Out  output  4  registered destination
RegWrite_Out  output  1  Controll_Signals_Out[15] & ~Mem_Stall
Mem_Stall  output  1  freeze request to IF/ID/EX registers and PC

Behaviour:
- Reset (rest=0, asynchronous):
  - All pipeline registers cleared; FSM to IDLE; cnt = 0.
  - All outputs 0 while in reset, Mem_Stall included.
  - Memory contents not cleared; a pending store is dropped.
- EX/MEM register:
  - On each rising edge with Mem_Stall=0, capture all *_In inputs.
  - With Mem_Stall=1, hold all captured values.
- Derived signals:
  - mem_op = MemRead | MemWrite of the registered control word.
  - Address = EXMEMData[ADDR_W-1:0]; upper bits ignored, no fault.
- FSM states:
  - IDLE: no access in progress.
  - BUSY: access in progress; 4-bit cnt counts access cycles from 0.
- Transitions:
  - IDLE, mem_op=1, MEM_LATENCY>1 -> BUSY, cnt <= 1.
  - IDLE, mem_op=1, MEM_LATENCY=1 -> stays IDLE; access completes this cycle.
  - BUSY, cnt < MEM_LATENCY-1 -> cnt <= cnt+1.
  - BUSY, cnt = MEM_LATENCY-1 -> IDLE, cnt <= 0.
- Final cycle: the cycle with (IDLE & mem_op & MEM_LATENCY=1) or (BUSY & cnt=MEM_LATENCY-1).
- Mem_Stall (combinational): 1 when mem_op=1 and not in the final cycle, else 0.
  - A load/store therefore holds the stage for exactly MEM_LATENCY cycles.
  - Non-memory instructions take 1 cycle.
- Store: the array is written at the rising edge ending the final cycle. Exactly one write per store, independent of latency.
- Load:
  - MemData_Out = array[address] (asynchronous read), valid in the final cycle.
  - MemData_Out = 0 whenever MemRead=0 or the access is not in its final cycle.
- MemRead and MemWrite both 1: treated as a store; MemData_Out = 0; RegWrite_Out follows bit 15 unchanged.
- Back-to-back memory instructions: the next access starts in the cycle after the final cycle (cnt restarts at 0/1). No bubble is inserted beyond the latency.
- Read-after-write, same address, consecutive instructions: the load returns the newly stored value, because the write commits before the load's final cycle.
- Forwarding: EXMEMData is valid every cycle, stall or not.
- RegWrite_Out is suppressed while stalled, so MEM/WB captures a load result only once.
- Reset asserted mid-access: the access is aborted with no array write; Mem_Stall drops immediately.

Test Plan:
- Reset: rest=0 then released -> all outputs 0, Mem_Stall=0. Memory preloaded 0xBEEF at 0x10 still reads 0xBEEF afterwards.
- ALU op, ctrl=0x8000, AluResult_In=0x1234, Rd_In=5 -> one cycle later EXMEMData=WB_Data_Out=0x1234, Rd_Out=5, RegWrite_Out=1, Mem_Stall never 1.
- Store then load, MEM_LATENCY=2: store 0xA5A5 to 0x0020 (ctrl=0x0800), then load 0x0020 (ctrl=0xB000) -> Mem_Stall pattern 1,0,1,0; load final cycle MemData_Out=WB_Data_Out=0xA5A5, RegWrite_Out=1 for exactly one cycle.
- MEM_LATENCY=4 load -> Mem_Stall high for exactly 3 cycles; RegWrite_Out=0 during stall. Upstream inputs changing during stall are ignored.
- Address wrap: store 0x1111 with AluResult_In=0x0120 (ADDR_W=8) -> load from 0x0020 returns 0x1111.
- Reset mid-access: MEM_LATENCY=4, store 0x7777 to 0x30, assert rest at cnt=2 -> location 0x30 keeps its old value, Mem_Stall=0, FSM IDLE.

Source files
------------

// File: rtl/mem_stage_if.sv
// Execute-to-memory stage bus: EX/MEM inputs from execute and MEM/WB-side results back out.
// The master modport is the upstream/observer side; the slave modport belongs to mem_stage.
interface mem_stage_if;
  logic [15:0] Controll_Signals_In;
  logic [3:0]  OpCode_In;
  logic [15:0] AluResult_In;
  logic [15:0] Store_Data_In;
  logic [3:0]  Rd_In;
  logic [15:0] Controll_Signals_Out;
  logic [3:0]  OpCode_Out;
  logic [15:0] EXMEMData;
  logic [15:0] WB_Data_Out;
  logic [15:0] MemData_Out;
  logic [3:0]  Rd_Out;
  logic        RegWrite_Out;
  logic        Mem_Stall;

  modport master (
    output Controll_Signals_In, OpCode_In, AluResult_In, Store_Data_In, Rd_In,
    input  Controll_Signals_Out, OpCode_Out, EXMEMData, WB_Data_Out, MemData_Out,
           Rd_Out, RegWrite_Out, Mem_Stall
  );

  modport slave (
    input  Controll_Signals_In, OpCode_In, AluResult_In, Store_Data_In, Rd_In,
    output Controll_Signals_Out, OpCode_Out, EXMEMData, WB_Data_Out, MemData_Out,
           Rd_Out, RegWrite_Out, Mem_Stall
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register, multi-cycle data memory and access FSM.
// Loads/stores hold the stage for MEM_LATENCY cycles via Mem_Stall; other instructions pass in one.
module mem_stage #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rest,
  mem_stage_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned RD_W   = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);
  localparam bit SINGLE_CYCLE = (MEM_LATENCY == 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [OP_W-1:0]    op_q;
  logic [DATA_W-1:0]  alu_q;
  logic [DATA_W-1:0]  store_q;
  logic [RD_W-1:0]    rd_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               mem_op_c;
  logic               final_c;
  logic               stall_c;
  logic               store_c;
  logic               load_c;
  logic [ADDR_W-1:0]  addr_c;
  logic [DATA_W-1:0]  rdata_c;

  // Access decode: a read+write word is treated as a store
  assign mem_op_c = ctrl_q[12] | ctrl_q[11];
  assign final_c  = mem_op_c & (((state_q == IDLE) && SINGLE_CYCLE) ||
                                ((state_q == BUSY) && (cnt_q == LAST_CNT)));
  assign stall_c  = mem_op_c & ~final_c;
  assign store_c  = ctrl_q[11] & final_c;
  assign load_c   = ctrl_q[12] & ~ctrl_q[11] & final_c;
  assign addr_c   = alu_q[ADDR_W-1:0];
  assign rdata_c  = load_c ? mem_q[addr_c] : '0;

  // EX/MEM pipeline register, frozen while the access is in progress
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      ctrl_q  <= '0;
      op_q    <= '0;
      alu_q   <= '0;
      store_q <= '0;
      rd_q    <= '0;
    end else if (!stall_c) begin
      ctrl_q  <= bus.Controll_Signals_In;
      op_q    <= bus.OpCode_In;
      alu_q   <= bus.AluResult_In;
      store_q <= bus.Store_Data_In;
      rd_q    <= bus.Rd_In;
    end
  end

  // Access FSM: cnt tracks elapsed cycles of the current access
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op_c && !SINGLE_CYCLE) begin
            state_q <= BUSY;
            cnt_q   <= CNT_W'(1);
          end
        end
        BUSY: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Data array is never reset; a reset clears ctrl_q, so no store can commit
  always_ff @(posedge clk) begin
    if (store_c) begin
      mem_q[addr_c] <= store_q;
    end
  end

  assign bus.Controll_Signals_Out = ctrl_q;
  assign bus.OpCode_Out           = op_q;
  assign bus.EXMEMData            = alu_q;
  assign bus.Rd_Out               = rd_q;
  assign bus.MemData_Out          = rdata_c;
  assign bus.WB_Data_Out          = ctrl_q[13] ? rdata_c : alu_q;
  assign bus.RegWrite_Out         = ctrl_q[15] & ~stall_c;
  assign bus.Mem_Stall            = stall_c;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (latency 1, 2, 4) share random stimulus and are
// compared every cycle against an instruction-level model, plus directed literal checks.
module tb_mem_stage;
  logic clk  = 1'b0;
  logic rest = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if b1 ();
  mem_stage_if b2 ();
  mem_stage_if b4 ();

  mem_stage #(.ADDR_W(8), .MEM_LATENCY(1)) u_l1 (.clk(clk), .rest(rest), .bus(b1));
  mem_stage #(.ADDR_W(8), .MEM_LATENCY(2)) u_l2 (.clk(clk), .rest(rest), .bus(b2));
  mem_stage #(.ADDR_W(8), .MEM_LATENCY(4)) u_l4 (.clk(clk), .rest(rest), .bus(b4));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance holds one instruction plus how many cycles it has spent in the stage
  logic [15:0] m_ctrl [3];
  logic [3:0]  m_op   [3];
  logic [15:0] m_alu  [3];
  logic [15:0] m_sd   [3];
  logic [3:0]  m_rd   [3];
  int          m_age  [3];
  logic [15:0] m_mem  [3][256];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic bit m_stall(input int k);
    bit is_mem = m_ctrl[k][12] | m_ctrl[k][11];
    return is_mem && (m_age[k] < lat(k) - 1);
  endfunction

  function automatic logic [15:0] m_rdata(input int k);
    if (m_ctrl[k][12] && !m_ctrl[k][11] && !m_stall(k)) return m_mem[k][m_alu[k][7:0]];
    return 16'h0;
  endfunction

  function automatic logic [73:0] m_exp(input int k);
    logic [15:0] rd  = m_rdata(k);
    logic [15:0] wb  = m_ctrl[k][13] ? rd : m_alu[k];
    logic        st  = m_stall(k);
    logic        rw  = m_ctrl[k][15] & ~st;
    return {m_ctrl[k], m_op[k], m_alu[k], wb, rd, m_rd[k], rw, st};
  endfunction

  always @(posedge clk or negedge rest) begin
    if (!rest) begin
      for (int k = 0; k < 3; k++) begin
        m_ctrl[k] <= '0; m_op[k] <= '0; m_alu[k] <= '0; m_sd[k] <= '0; m_rd[k] <= '0;
        m_age[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_stall(k)) begin
          m_age[k] <= m_age[k] + 1;
        end else begin
          if (m_ctrl[k][11]) m_mem[k][m_alu[k][7:0]] <= m_sd[k];
          m_ctrl[k] <= b1.Controll_Signals_In;
          m_op[k]   <= b1.OpCode_In;
          m_alu[k]  <= b1.AluResult_In;
          m_sd[k]   <= b1.Store_Data_In;
          m_rd[k]   <= b1.Rd_In;
          m_age[k]  <= 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output of every instance
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_lat1", {b1.Controll_Signals_Out, b1.OpCode_Out, b1.EXMEMData, b1.WB_Data_Out,
                       b1.MemData_Out, b1.Rd_Out, b1.RegWrite_Out, b1.Mem_Stall}, m_exp(0));
      chk("cyc_lat2", {b2.Controll_Signals_Out, b2.OpCode_Out, b2.EXMEMData, b2.WB_Data_Out,
                       b2.MemData_Out, b2.Rd_Out, b2.RegWrite_Out, b2.Mem_Stall}, m_exp(1));
      chk("cyc_lat4", {b4.Controll_Signals_Out, b4.OpCode_Out, b4.EXMEMData, b4.WB_Data_Out,
                       b4.MemData_Out, b4.Rd_Out, b4.RegWrite_Out, b4.Mem_Stall}, m_exp(2));
    end
  end

  task automatic set_in(input logic [15:0] c, input logic [3:0] op, input logic [15:0] alu,
                        input logic [15:0] sd, input logic [3:0] rd);
    b1.Controll_Signals_In = c; b1.OpCode_In = op; b1.AluResult_In = alu;
    b1.Store_Data_In = sd; b1.Rd_In = rd;
    b2.Controll_Signals_In = c; b2.OpCode_In = op; b2.AluResult_In = alu;
    b2.Store_Data_In = sd; b2.Rd_In = rd;
    b4.Controll_Signals_In = c; b4.OpCode_In = op; b4.AluResult_In = alu;
    b4.Store_Data_In = sd; b4.Rd_In = rd;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((b1.Mem_Stall || b2.Mem_Stall || b4.Mem_Stall) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout stall still high after %0d cycles", n);
    end
  endtask

  // Present one instruction for a single edge; returns at the negedge after capture
  task automatic issue(input logic [15:0] c, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [3:0] rd);
    wait_idle();
    set_in(c, 4'hA, alu, sd, rd);
    @(negedge clk);
    set_in(16'h0, 4'h0, 16'h0, 16'h0, 4'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] c;
    logic [15:0] a;
    set_in(16'h0, 4'h0, 16'h0, 16'h0, 4'h0);
    #1 rest = 1'b0;
    #1 chk_en = 1'b1;
    chk("reset_outputs", {b2.Controll_Signals_Out, b2.OpCode_Out, b2.EXMEMData, b2.WB_Data_Out,
                          b2.MemData_Out, b2.Rd_Out, b2.RegWrite_Out, b2.Mem_Stall}, 74'd0);
    @(negedge clk);
    #2 rest = 1'b1;
    @(negedge clk);

    // Fill every location so later loads always read defined data
    for (int i = 0; i < 256; i++) begin
      issue(16'h0800, 16'(i), (i == 16) ? 16'hBEEF : 16'(i * 16'h9E37) ^ 16'h5A5A, 4'h0);
    end
    wait_idle();

    // Reset leaves memory intact
    #2 rest = 1'b0;
    #1 chk("reset_stall", {73'd0, b2.Mem_Stall}, 74'd0);
    @(negedge clk);
    #2 rest = 1'b1;
    @(negedge clk);
    issue(16'hB000, 16'h0010, 16'h0, 4'h7);
    @(negedge clk);
    chk("beef_after_reset", {58'd0, b2.MemData_Out}, {58'd0, 16'hBEEF});

    // Plain ALU op
    wait_idle();
    issue(16'h8000, 16'h1234, 16'h0, 4'h5);
    chk("alu_exmem", {58'd0, b2.EXMEMData}, {58'd0, 16'h1234});
    chk("alu_wb", {58'd0, b2.WB_Data_Out}, {58'd0, 16'h1234});
    chk("alu_rd_rw_st", {68'd0, b2.Rd_Out, b2.RegWrite_Out, b2.Mem_Stall}, {68'd0, 4'd5, 1'b1, 1'b0});

    // Store then load, latency 2
    wait_idle();
    set_in(16'h0800, 4'h1, 16'h0020, 16'hA5A5, 4'h0);
    @(negedge clk);
    chk("sl_stall0", {73'd0, b2.Mem_Stall}, {73'd0, 1'b1});
    set_in(16'hB000, 4'h2, 16'h0020, 16'h0, 4'h3);
    @(negedge clk);
    chk("sl_stall1", {73'd0, b2.Mem_Stall}, {73'd0, 1'b0});
    @(negedge clk);
    chk("sl_stall2_rw", {72'd0, b2.Mem_Stall, b2.RegWrite_Out}, {72'd0, 1'b1, 1'b0});
    set_in(16'h0, 4'h0, 16'h0, 16'h0, 4'h0);
    @(negedge clk);
    chk("sl_final", {41'd0, b2.Mem_Stall, b2.MemData_Out, b2.WB_Data_Out},
        {41'd0, 1'b0, 16'hA5A5, 16'hA5A5});
    chk("sl_rw_once", {73'd0, b2.RegWrite_Out}, {73'd0, 1'b1});
    @(negedge clk);
    chk("sl_rw_after", {73'd0, b2.RegWrite_Out}, 74'd0);

    // Latency-4 load while upstream inputs churn
    wait_idle();
    set_in(16'hB000, 4'h4, 16'h0020, 16'h0, 4'h9);
    @(negedge clk);
    n = 0;
    while (b4.Mem_Stall && n < 20) begin
      chk("lat4_rw_low", {73'd0, b4.RegWrite_Out}, 74'd0);
      set_in(16'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
      @(negedge clk);
      n++;
    end
    chk("lat4_stall_len", 74'(n), 74'd3);
    chk("lat4_final", {54'd0, b4.MemData_Out, b4.Rd_Out}, {54'd0, 16'hA5A5, 4'h9});
    set_in(16'h0, 4'h0, 16'h0, 16'h0, 4'h0);

    // Address wrap: upper bits of the ALU result are ignored
    issue(16'h0800, 16'h0120, 16'h1111, 4'h0);
    issue(16'hB000, 16'h0020, 16'h0, 4'h2);
    @(negedge clk);
    chk("wrap_load", {58'd0, b2.MemData_Out}, {58'd0, 16'h1111});

    // Reset in the middle of a latency-4 store aborts the write
    issue(16'h0800, 16'h0030, 16'h5555, 4'h0);
    issue(16'h0800, 16'h0030, 16'h7777, 4'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rest = 1'b0;
    #1 chk("abort_stall", {73'd0, b4.Mem_Stall}, 74'd0);
    @(negedge clk);
    #2 rest = 1'b1;
    @(negedge clk);
    issue(16'hB000, 16'h0030, 16'h0, 4'h1);
    n = 0;
    while (b4.Mem_Stall && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_keeps_old", {58'd0, b4.MemData_Out}, {58'd0, 16'h5555});

    // Random traffic, occasional asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      c = 16'($urandom);
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[7:4] = 4'h0;
      set_in(c, 4'($urandom), a, 16'($urandom), 4'($urandom));
      if ($urandom_range(0, 299) == 0) begin
        #2 rest = 1'b0;
        #2 rest = 1'b1;
      end
      @(negedge clk);
    end
    set_in(16'h0, 4'h0, 16'h0, 16'h0, 4'h0);
    wait_idle();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
